outpass_n_pipe_config: RTL and testbench
========================================

// Module: outpass_n_pipe_config
// PURPOSE
//  Parametrised output-pass BEL: NUM_CH fabric signals driven to EXTERNAL tile outputs.
//  Per channel, frame config bits select the mode: combinational bypass, 1..2**DEPTH_W
//  stage delay line, CE-gated sample-and-hold, or registered rising-edge pulse.
//  Adds a synchronous reset and programmable pipeline depth to the fixed 4-channel
//  flop/bypass output pass.
// PARAMETERS
//  NUM_CH        4    number of independent channels
//  DEPTH_W       2    delay-select width; max delay line depth MAX_D = 2**DEPTH_W
//  NoConfigBits  16   = NUM_CH*(2+DEPTH_W); set manually to match NUM_CH and DEPTH_W
// PORTS
//  UserCLK     in   1             user clock (EXTERNAL, SHARED_PORT)
//  UserRST     in   1             synchronous active-high reset (EXTERNAL, SHARED_PORT)
//  I           in   NUM_CH        fabric data in, from the switch matrix
//  CE          in   1             clock enable, from the switch matrix; used by modes 2 and 3
//  O           out  NUM_CH        tile outputs (EXTERNAL)
//  ConfigBits  in   NoConfigBits  frame config (GLOBAL)
// BEHAVIOUR
//  Config field for ch k: ConfigBits[k*(2+DEPTH_W) +: 2+DEPTH_W].
//   [1:0] = MODE; [2+:DEPTH_W] = DSEL.
//  Config is static during operation. A config change takes effect combinationally on
//   the output mux; register contents are not flushed.
//  Per-channel state:
//   - shift register SR[0..MAX_D-1]
//   - hold register H
//   - prev register P
//   - pulse register E
//  All per-channel state clears to 0 on any UserCLK edge with UserRST=1.
//  UserRST has priority over CE and all data.
//  SR shifts every clock regardless of MODE and CE: SR[0]<=I[k], SR[j]<=SR[j-1].
//  MODE 0, bypass: O[k] = I[k] combinationally. 0-cycle latency. Unaffected by reset.
//  MODE 1, delay: O[k] = SR[DSEL]. Latency DSEL+1 cycles; DSEL=0 gives a single flop.
//   After reset, O=0 until the first post-reset sample has propagated through DSEL+1 stages.
//  MODE 2, sample-and-hold: H<=I[k] when CE=1, else H holds. O[k]=H. Latency 1 cycle.
//  MODE 3, rising-edge pulse:
//   - P updates (P<=I[k]) only when CE=1; E<=CE & I[k] & ~P; O[k]=E.
//   - One-cycle pulse per sampled 0->1 transition; latency 1.
//   - P resets to 0, so I held high through reset release yields one pulse on the first
//     CE=1 cycle after reset.
//  Registered-mode outputs (MODE 1-3) read 0 in the cycle after reset asserts.
//  Registered-mode outputs stay 0 while UserRST is held.
//  Channels are fully independent; no cross-channel state.
//  Mid-operation reset discards in-flight delay-line data; no partial pulse is emitted.
//  Width rule: DSEL is unsigned and its full range is legal (0..MAX_D-1); no out-of-range tap.
// TESTING
//  1. MODE=0 all ch, I toggling, UserRST=1 -> O==I same cycle, reset ignored.
//  2. ch0 MODE=1 DSEL=3: single-cycle pulse I[0]=1 at cycle t -> O[0]=1 only at t+4.
//     Same stimulus with DSEL=0 -> O[0]=1 only at t+1.
//  3. ch1 MODE=2: I[1]=1, CE=1 at t -> O[1]=1 from t+1.
//     Then I[1]=0 with CE=0 for 5 cycles -> O[1] stays 1.
//     CE=1 -> O[1]=0 next cycle.
//  4. ch2 MODE=3, CE=1, I[2] low->high held 4 cycles -> O[2]=1 for exactly one cycle.
//     Repeat with CE=0 during the edge -> O[2] stays 0.
//  5. ch0 MODE=1 DSEL=3 streaming 1s, assert UserRST for 1 cycle mid-stream -> O[0]=0
//     next cycle and for 4 cycles after release, then 1.
//  6. Mixed config: ch0..3 in modes 0..3 with random I/CE for 1000 cycles -> each
//     channel matches its independent reference model; no crosstalk.

Source files
------------

// File: rtl/outpass_n_pipe_config.sv
// Configurable output-pass BEL: per-channel bypass, programmable delay line,
// CE-gated sample-and-hold or registered rising-edge pulse, with synchronous reset.
module outpass_n_pipe_config #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DEPTH_W      = 2,
  parameter int unsigned NoConfigBits = 16
) (
  input  logic                    UserCLK,
  input  logic                    UserRST,
  input  logic [NUM_CH-1:0]       I,
  input  logic                    CE,
  output logic [NUM_CH-1:0]       O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int unsigned MaxD   = 2 ** DEPTH_W;
  localparam int unsigned FieldW = 2 + DEPTH_W;

  logic [MaxD-1:0]   sr_q [NUM_CH];
  logic [MaxD-1:0]   sr_d [NUM_CH];
  logic [NUM_CH-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0] prev_q, prev_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;

  // Reset wins over CE and data; the delay line shifts regardless of mode and CE.
  always_comb begin
    hold_d  = hold_q;
    prev_d  = prev_q;
    pulse_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sr_d[k] = '0;
      if (!UserRST) begin
        sr_d[k]    = {sr_q[k][MaxD-2:0], I[k]};
        hold_d[k]  = CE ? I[k] : hold_q[k];
        prev_d[k]  = CE ? I[k] : prev_q[k];
        pulse_d[k] = CE & I[k] & ~prev_q[k];
      end else begin
        hold_d[k]  = 1'b0;
        prev_d[k]  = 1'b0;
        pulse_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge UserCLK) begin
    for (int k = 0; k < NUM_CH; k++) begin
      sr_q[k] <= sr_d[k];
    end
    hold_q  <= hold_d;
    prev_q  <= prev_d;
    pulse_q <= pulse_d;
  end

  // Output mux follows config combinationally; registers are never flushed on a change.
  always_comb begin
    O = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      logic [1:0]         mode;
      logic [DEPTH_W-1:0] dsel;
      mode = ConfigBits[k*FieldW +: 2];
      dsel = ConfigBits[k*FieldW + 2 +: DEPTH_W];
      case (mode)
        2'd0:    O[k] = I[k];
        2'd1:    O[k] = sr_q[k][dsel];
        2'd2:    O[k] = hold_q[k];
        default: O[k] = pulse_q[k];
      endcase
    end
  end

endmodule

// File: tb/tb_outpass_n_pipe_config.sv
// Directed and randomised checks of outpass_n_pipe_config with default parameters.
module tb_outpass_n_pipe_config;

  logic        clk;
  logic        rst;
  logic [3:0]  din;
  logic        ce;
  logic [3:0]  dout;
  logic [15:0] cfg;

  int n_checks = 0;
  int n_fail   = 0;

  outpass_n_pipe_config #(
    .NUM_CH      (4),
    .DEPTH_W     (2),
    .NoConfigBits(16)
  ) dut (
    .UserCLK   (clk),
    .UserRST   (rst),
    .I         (din),
    .CE        (ce),
    .O         (dout),
    .ConfigBits(cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // All registered modes read 0 after reset, and stay 0 while reset is held.
    cfg = 16'hF9E1;
    din = 4'hF;
    ce  = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (dout !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", c, dout, 4'h0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    logic [3:0] pats [4];
    pats[0] = 4'h5; pats[1] = 4'hA; pats[2] = 4'hF; pats[3] = 4'h0;
    cfg = 16'h0000;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      din = pats[c];
      #1;
      n_checks++;
      if (dout !== pats[c]) begin
        n_fail++;
        $display("FAIL bypass pat=%0d got=%h want=%h", c, dout, pats[c]);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_delay();
    for (int dsel = 0; dsel < 4; dsel += 3) begin
      cfg = {12'h000, dsel[1:0], 2'b01};
      din = 4'h0;
      do_reset();
      tick();
      din[0] = 1'b1;
      for (int c = 1; c <= 7; c++) begin
        tick();
        din[0] = 1'b0;
        n_checks++;
        if (dout[0] !== (c == dsel + 1)) begin
          n_fail++;
          $display("FAIL delay dsel=%0d cyc=%0d got=%b want=%b", dsel, c, dout[0],
                   (c == dsel + 1));
        end
      end
    end
  endtask

  task automatic test_hold();
    cfg = 16'h0020;
    din = 4'h0;
    ce  = 1'b0;
    do_reset();
    din[1] = 1'b1;
    ce = 1'b1;
    tick();
    n_checks++;
    if (dout[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_capture got=%b want=1", dout[1]);
    end
    din[1] = 1'b0;
    ce = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (dout[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_keep cyc=%0d got=%b want=1", c, dout[1]);
      end
    end
    ce = 1'b1;
    tick();
    n_checks++;
    if (dout[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_update got=%b want=0", dout[1]);
    end
  endtask

  task automatic test_pulse();
    cfg = 16'h0300;
    din = 4'h0;
    ce  = 1'b1;
    do_reset();
    tick();
    din[2] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++;
      if (dout[2] !== (c == 1)) begin
        n_fail++;
        $display("FAIL pulse_edge cyc=%0d got=%b want=%b", c, dout[2], (c == 1));
      end
    end
    din[2] = 1'b0;
    tick();
    tick();
    ce = 1'b0;
    din[2] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++;
      if (dout[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL pulse_no_ce cyc=%0d got=%b want=0", c, dout[2]);
      end
    end
    // Input held high through reset release: one pulse on the first CE cycle.
    ce = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++;
      if (dout[2] !== (c == 1)) begin
        n_fail++;
        $display("FAIL pulse_post_reset cyc=%0d got=%b want=%b", c, dout[2], (c == 1));
      end
    end
  endtask

  task automatic test_mid_reset();
    cfg = 16'h000D;
    din = 4'h1;
    ce  = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    n_checks++;
    if (dout[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_fill got=%b want=1", dout[0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (dout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear got=%b want=0", dout[0]);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++;
      if (dout[0] !== (c >= 4)) begin
        n_fail++;
        $display("FAIL midrst_refill cyc=%0d got=%b want=%b", c, dout[0], (c >= 4));
      end
    end
  endtask

  task automatic test_mixed_random();
    logic [3:0] hist;
    logic       m_hold, m_prev, m_pulse;
    logic       exp1;
    int         errs;
    // ch0 bypass, ch1 delay 3, ch2 hold, ch3 pulse
    cfg = 16'h3290;
    din = 4'h0;
    ce  = 1'b0;
    do_reset();
    hist = '0; m_hold = 1'b0; m_prev = 1'b0; m_pulse = 1'b0;
    errs = 0;
    for (int c = 0; c < 1000; c++) begin
      din = 4'($urandom_range(0, 15));
      ce  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 49) == 0);
      #1;
      if (dout[0] !== din[0]) begin
        errs++;
        if (errs < 10) $display("FAIL mix_ch0 cyc=%0d got=%b want=%b", c, dout[0], din[0]);
      end
      tick();
      if (rst) begin
        hist = '0; m_hold = 1'b0; m_prev = 1'b0; m_pulse = 1'b0;
      end else begin
        hist    = {hist[2:0], din[1]};
        m_pulse = ce && din[3] && !m_prev;
        if (ce) begin
          m_hold = din[2];
          m_prev = din[3];
        end
      end
      exp1 = hist[2];
      if (dout[3:1] !== {m_pulse, m_hold, exp1}) begin
        errs++;
        if (errs < 10)
          $display("FAIL mix_ch321 cyc=%0d got=%b want=%b", c, dout[3:1],
                   {m_pulse, m_hold, exp1});
      end
    end
    rst = 1'b0;
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL mixed_random errors got=%0d want=0", errs);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 4'h0;
    ce  = 1'b0;
    cfg = 16'h0000;
    test_reset();
    test_bypass();
    test_delay();
    test_hold();
    test_pulse();
    test_mid_reset();
    test_mixed_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
